// File: rtl/arcino_fetch_requester.sv
// ARCINO fetch request front end: issues word reads, tracks outstanding responses, pushes words into the fetch FIFO.
// Define ARCINO_FETCH_2OUTSTANDING_EN to allow two outstanding requests (default: one).
module arcino_fetch_requester #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        fifo_valid_o,
  output logic [31:0] fifo_addr_o,
  output logic [31:0] fifo_rdata_o,
  input  logic        fifo_ready_i,
  output logic        fifo_clear_o,
  output logic        busy_o
);

`ifdef ARCINO_FETCH_2OUTSTANDING_EN
  localparam int MAX_OUT = 2;
  localparam int CW      = 2;
`else
  localparam int MAX_OUT = 1;
  localparam int CW      = 1;
`endif
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  typedef enum logic {
    IDLE,
    WAIT_GNT
  } state_e;

  state_e          state_q, state_d;
  logic [29:0]     fetch_addr_q, fetch_addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   dsc_q, dsc_d;
  logic [31:0]     queue_q [MAX_OUT];
  logic [31:0]     queue_d [MAX_OUT];
  logic            first_q, first_d;
  logic            first_addr_q, first_addr_d;

  logic            granted;
  logic [CW-1:0]   cnt_after;
  logic [CW-1:0]   enq_idx;
  logic            issue_ok;
  logic [31:0]     push_addr;
  logic            unused_bit0;

  assign unused_bit0 = branch_addr_i[0];

  assign instr_addr_o = {fetch_addr_q, 2'b00};
  assign fifo_addr_o  = queue_q[0];
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_clear_o = branch_i;
  assign busy_o       = instr_req_o | (cnt_q != '0);

  // The issue condition looks at the count after this cycle's grant/response so that
  // a response frees its slot for a request in the very next cycle.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    cnt_d        = cnt_q;
    dsc_d        = dsc_q;
    queue_d      = queue_q;
    first_d      = first_q;
    first_addr_d = first_addr_q;

    instr_req_o  = (state_q == WAIT_GNT) && !branch_i;
    granted      = instr_req_o & instr_gnt_i;
    cnt_after    = cnt_q + CW'(granted) - CW'(instr_rvalid_i);
    issue_ok     = req_i & fifo_ready_i & (cnt_after < MAX_CNT) & !branch_i;
    fifo_valid_o = instr_rvalid_i & (dsc_q == '0) & !branch_i;
    enq_idx      = cnt_q - CW'(instr_rvalid_i);
    push_addr    = first_q ? {fetch_addr_q, first_addr_q, 1'b0} : {fetch_addr_q, 2'b00};

    if (instr_rvalid_i) begin
`ifdef ARCINO_FETCH_2OUTSTANDING_EN
      queue_d[0] = queue_q[1];
`endif
      if (dsc_q != '0) dsc_d = dsc_q - 1'b1;
    end

    if (granted) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        if (CW'(i) == enq_idx) queue_d[i] = push_addr;
      end
      fetch_addr_d = fetch_addr_q + 30'd1;
      first_d      = 1'b0;
    end

    cnt_d = cnt_after;

    case (state_q)
      IDLE:     if (issue_ok) state_d = WAIT_GNT;
      WAIT_GNT: if (granted) state_d = issue_ok ? WAIT_GNT : IDLE;
      default:  state_d = IDLE;
    endcase

    // Responses still in flight at a redirect belong to the old stream and are dropped.
    if (branch_i) begin
      fetch_addr_d = branch_addr_i[31:2];
      dsc_d        = cnt_q - CW'(instr_rvalid_i);
      first_d      = 1'b1;
      first_addr_d = branch_addr_i[1];
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fetch_addr_q <= BOOT_ADDR[31:2];
      cnt_q        <= '0;
      dsc_q        <= '0;
      for (int i = 0; i < MAX_OUT; i++) queue_q[i] <= '0;
      first_q      <= 1'b0;
      first_addr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      cnt_q        <= cnt_d;
      dsc_q        <= dsc_d;
      queue_q      <= queue_d;
      first_q      <= first_d;
      first_addr_q <= first_addr_d;
    end
  end

endmodule

// File: tb/tb_arcino_fetch_requester.sv
// Self-checking bench for arcino_fetch_requester: queue-based behavioural model checked every cycle,
// directed scenarios pinned with literal addresses, then randomized traffic.
module tb_arcino_fetch_requester;

`ifdef ARCINO_FETCH_2OUTSTANDING_EN
  localparam int MAX_OUT = 2;
`else
  localparam int MAX_OUT = 1;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = '0;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_ready_i = 1'b0;
  logic        fifo_clear_o;
  logic        busy_o;

  arcino_fetch_requester dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .branch_addr_i  (branch_addr_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_addr_o    (fifo_addr_o),
    .fifo_rdata_o   (fifo_rdata_o),
    .fifo_ready_i   (fifo_ready_i),
    .fifo_clear_o   (fifo_clear_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_compared = 0;
  int n_mismatched = 0;

  // Behavioural model: the list of addresses still owed a response, plus the fetch pointer.
  logic [29:0] m_fetch;
  logic        m_active;
  logic [31:0] m_q[$];
  int          m_discard;
  logic        m_first;
  logic        m_first_off;

  logic        s_req, s_valid, s_clear, s_busy;
  logic [31:0] s_addr, s_faddr;
  logic [31:0] req_log[$];
  logic [31:0] push_log[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_entry(input string name, input logic [31:0] q[$], input int idx,
                             input logic [31:0] exp);
    if (idx < q.size()) check_output(name, q[idx], exp);
    else begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: entry %0d missing (only %0d logged), expected %h", name, idx, q.size(), exp);
    end
  endtask

  task automatic model_reset();
    m_fetch = 30'h0000_0020;
    m_active = 1'b0;
    m_q.delete();
    m_discard = 0;
    m_first = 1'b0;
    m_first_off = 1'b0;
  endtask

  // Drives one cycle of inputs, compares every output against the model mid-cycle,
  // then advances the model across the clock edge.
  task automatic apply_stimulus(input logic req, input logic ready, input logic branch,
                                input logic [31:0] target, input logic gnt,
                                input logic rvalid, input logic [31:0] rdata);
    logic exp_req, exp_push, granted;
    req_i = req; fifo_ready_i = ready; branch_i = branch; branch_addr_i = target;
    instr_gnt_i = gnt; instr_rvalid_i = rvalid; instr_rdata_i = rdata;
    @(negedge clk_i);
    s_req = instr_req_o; s_addr = instr_addr_o; s_valid = fifo_valid_o;
    s_faddr = fifo_addr_o; s_clear = fifo_clear_o; s_busy = busy_o;

    exp_req  = m_active && !branch;
    exp_push = rvalid && (m_discard == 0) && !branch;
    check_output("instr_req_o", {31'd0, s_req}, {31'd0, exp_req});
    check_output("instr_addr_o", s_addr, {m_fetch, 2'b00});
    check_output("fifo_valid_o", {31'd0, s_valid}, {31'd0, exp_push});
    if (exp_push && m_q.size() > 0) begin
      check_output("fifo_addr_o", s_faddr, m_q[0]);
      check_output("fifo_rdata_o", fifo_rdata_o, rdata);
    end
    check_output("fifo_clear_o", {31'd0, s_clear}, {31'd0, branch});
    check_output("busy_o", {31'd0, s_busy}, {31'd0, exp_req || (m_q.size() != 0)});
    if (s_req && gnt) req_log.push_back(s_addr);
    if (s_valid) push_log.push_back(s_faddr);

    @(posedge clk_i);
    granted = exp_req && gnt;
    if (rvalid) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (!branch && m_discard > 0) m_discard--;
    end
    if (granted) begin
      m_q.push_back(m_first ? {m_fetch, m_first_off, 1'b0} : {m_fetch, 2'b00});
      m_first = 1'b0;
      m_fetch = m_fetch + 30'd1;
    end
    if (branch) begin
      m_fetch = target[31:2];
      m_discard = m_q.size();
      m_first = 1'b1;
      m_first_off = target[1];
      m_active = 1'b0;
    end else if (!(m_active && !granted)) begin
      m_active = req && ready && (m_q.size() < MAX_OUT);
    end
    #1;
  endtask

  // Memory answers the oldest outstanding request every cycle.
  task automatic cycle_auto(input logic req, input logic branch, input logic [31:0] target);
    apply_stimulus(req, 1'b1, branch, target, 1'b1, m_q.size() > 0, $urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) cycle_auto(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    $display("[TB] start, MAX_OUT=%0d", MAX_OUT);
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Reset values
    apply_stimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_output("reset addr", s_addr, 32'h0000_0080);
    check_output("reset req", {31'd0, s_req}, 32'd0);
    check_output("reset busy", {31'd0, s_busy}, 32'd0);
    check_output("reset fifo_addr", s_faddr, 32'h0);

    // Straight-line fetch from the boot address
    req_log.delete(); push_log.delete();
    for (int i = 0; i < 6; i++) cycle_auto(1'b1, 1'b0, 32'h0);
    check_output("seq req count", req_log.size(), (MAX_OUT == 2) ? 32'd5 : 32'd3);
    check_entry("seq req0", req_log, 0, 32'h0000_0080);
    check_entry("seq req1", req_log, 1, 32'h0000_0084);
    check_entry("seq req2", req_log, 2, 32'h0000_0088);
    check_entry("seq push0", push_log, 0, 32'h0000_0080);
    check_entry("seq push1", push_log, 1, 32'h0000_0084);
    drain();
    check_output("seq drained busy", {31'd0, s_busy}, 32'd0);

    // Branch with requests outstanding
    for (int i = 0; i < MAX_OUT + 1; i++) apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 32'h0000_1002, 1'b1, 1'b0, 32'h0);
    check_output("branch clear", {31'd0, s_clear}, 32'd1);
    check_output("branch req drop", {31'd0, s_req}, 32'd0);
    req_log.delete(); push_log.delete();
    for (int i = 0; i < 8; i++) cycle_auto(1'b1, 1'b0, 32'h0);
    check_entry("branch req0", req_log, 0, 32'h0000_1000);
    check_entry("branch req1", req_log, 1, 32'h0000_1004);
    check_entry("branch push0", push_log, 0, 32'h0000_1002);
    check_entry("branch push1", push_log, 1, 32'h0000_1004);
    drain();

    // FIFO not ready holds off requests, then a withheld grant with a branch in its third cycle
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check_output("not ready req", {31'd0, s_req}, 32'd0);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_output("ready edge req", {31'd0, s_req}, 32'd0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_output("ready next req", {31'd0, s_req}, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(1'b1, 1'b0, i == 3, 32'h0000_2000, 1'b0, 1'b0, 32'h0);
      if (i == 3) check_output("withheld branch req", {31'd0, s_req}, 32'd0);
      if (i == 5) check_output("withheld new addr", s_addr, 32'h0000_2000);
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drain();

    // Address wrap, branch target on the upper halfword
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'h0);
    req_log.delete(); push_log.delete();
    for (int i = 0; i < 6; i++) cycle_auto(1'b1, 1'b0, 32'h0);
    drain();
    check_entry("wrap req0", req_log, 0, 32'hFFFF_FFFC);
    check_entry("wrap req1", req_log, 1, 32'h0000_0000);
    check_entry("wrap push0", push_log, 0, 32'hFFFF_FFFE);
    check_entry("wrap push1", push_log, 1, 32'h0000_0000);

    // Branch coinciding with the last response
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0000_3000, 1'b0, 1'b1, 32'h1234_5678);
    check_output("branch+rvalid push", {31'd0, s_valid}, 32'd0);
    check_output("branch+rvalid busy", {31'd0, s_busy}, 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_output("branch+rvalid busy after", {31'd0, s_busy}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 20) == 0, $urandom,
                     ($urandom % 3) != 0, (m_q.size() > 0) && (($urandom % 5) < 3), $urandom);
    end
    drain();
    check_output("final busy", {31'd0, s_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
